// File: rtl/ef_smsdac_msenc8.sv
// 8-element mismatch-shaping encoder: 3-level tree of first-order switching blocks, one level
// per pipeline stage. Define EF_SMSDAC_DITH_EN to use LFSR dither for the switching-block choice.
module ef_smsdac_msenc8 #(
    parameter bit IDLE_HOLD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       in_vld,
    input  logic [3:0] d,
    input  logic [6:0] r,
    output logic       lfsr_adv,
    output logic [7:0] u,
    output logic       out_vld
);

    // Returns {extra_to_top, extra_to_bottom, next_bal, next_sgn} for one switching block.
    function automatic logic [3:0] sb_split(input logic odd, input logic bal, input logic sgn,
                                            input logic choose_plus);
        logic plus;
        logic nbal;
        logic nsgn;
        plus = 1'b0;
        nbal = bal;
        nsgn = sgn;
        if (odd) begin
            if (!bal) begin
                plus = ~sgn;
                nbal = 1'b1;
            end else begin
                plus = choose_plus;
                nbal = 1'b0;
                nsgn = choose_plus;
            end
        end
        return {odd & plus, odd & ~plus, nbal, nsgn};
    endfunction

    logic [3:0]      d0_q, d0_d;
    logic            v0_q, v0_d;
    logic [1:0][2:0] c1_q, c1_d;
    logic            v1_q, v1_d;
    logic [3:0][1:0] c2_q, c2_d;
    logic            v2_q, v2_d;
    logic [7:0]      u_q, u_d;
    logic            ov_q, ov_d;
    logic [6:0]      bal_q, bal_d;
    logic [6:0]      sgn_q, sgn_d;

    logic [6:0]      dith;
    logic [6:0][3:0] sp;
    logic [7:0]      leaf;

`ifdef EF_SMSDAC_DITH_EN
    assign dith     = r;
    assign lfsr_adv = v0_q | v1_q | v2_q;
`else
    // All-ones dither makes every free choice split +1 (extra unit to the top branch).
    logic unused_r;
    assign unused_r = ^r;
    assign dith     = 7'h7F;
    assign lfsr_adv = 1'b0;
`endif

    always_comb begin
        bal_d = bal_q;
        sgn_d = sgn_q;
        leaf  = 8'h00;

        d0_d = (d > 4'd8) ? 4'd8 : d;
        v0_d = in_vld;

        // Root: 0..8 split into two 0..4 counts
        sp[0]   = sb_split(d0_q[0], bal_q[0], sgn_q[0], dith[0]);
        c1_d[0] = d0_q[3:1] + {2'b00, sp[0][3]};
        c1_d[1] = d0_q[3:1] + {2'b00, sp[0][2]};
        if (v0_q) begin
            bal_d[0] = sp[0][1];
            sgn_d[0] = sp[0][0];
        end
        v1_d = v0_q;

        for (int n = 1; n < 3; n++) begin
            sp[n] = sb_split(c1_q[n-1][0], bal_q[n], sgn_q[n], dith[n]);
            c2_d[2*(n-1)]   = c1_q[n-1][2:1] + {1'b0, sp[n][3]};
            c2_d[2*(n-1)+1] = c1_q[n-1][2:1] + {1'b0, sp[n][2]};
            if (v1_q) begin
                bal_d[n] = sp[n][1];
                sgn_d[n] = sp[n][0];
            end
        end
        v2_d = v1_q;

        // Leaves: a count of 2 lights both elements, a count of 1 goes where the block steers it
        for (int k = 0; k < 4; k++) begin
            sp[3+k] = sb_split(c2_q[k][0], bal_q[3+k], sgn_q[3+k], dith[3+k]);
            leaf[2*k]   = c2_q[k][1] | sp[3+k][3];
            leaf[2*k+1] = c2_q[k][1] | sp[3+k][2];
            if (v2_q) begin
                bal_d[3+k] = sp[3+k][1];
                sgn_d[3+k] = sp[3+k][0];
            end
        end

        if (v2_q) begin
            u_d = leaf;
        end else if (IDLE_HOLD) begin
            u_d = u_q;
        end else begin
            u_d = 8'h00;
        end
        ov_d = v2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            d0_q  <= '0;
            v0_q  <= 1'b0;
            c1_q  <= '0;
            v1_q  <= 1'b0;
            c2_q  <= '0;
            v2_q  <= 1'b0;
            u_q   <= '0;
            ov_q  <= 1'b0;
            bal_q <= '1;
            sgn_q <= '0;
        end else begin
            d0_q  <= d0_d;
            v0_q  <= v0_d;
            c1_q  <= c1_d;
            v1_q  <= v1_d;
            c2_q  <= c2_d;
            v2_q  <= v2_d;
            u_q   <= u_d;
            ov_q  <= ov_d;
            bal_q <= bal_d;
            sgn_q <= sgn_d;
        end
    end

    assign u       = u_q;
    assign out_vld = ov_q;

endmodule

// File: tb/tb_ef_smsdac_msenc8.sv
// Scoreboard bench for ef_smsdac_msenc8; runs an IDLE_HOLD=1 and an IDLE_HOLD=0 instance in
// parallel. Works with or without EF_SMSDAC_DITH_EN.
module tb_ef_smsdac_msenc8;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       in_vld = 1'b0;
    logic [3:0] d = 4'd0;
    logic [6:0] r;
    logic [6:0] r_fix = 7'h7F;
    logic [6:0] lfsr = 7'h5A;
    bit         use_lfsr = 1'b0;
    logic       adv1, adv0, ov1, ov0;
    logic [7:0] u1, u0;

    typedef struct {
        bit         vld;
        bit         exact;
        logic [7:0] eu;
        int         cnt;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] hold1 = 8'h00;
    int         acc[7];

    assign r = use_lfsr ? lfsr : r_fix;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (adv1 === 1'b1) lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    ef_smsdac_msenc8 dut1 (
        .clk(clk), .rst_b(rst_b), .in_vld(in_vld), .d(d), .r(r),
        .lfsr_adv(adv1), .u(u1), .out_vld(ov1)
    );

    ef_smsdac_msenc8 #(.IDLE_HOLD(1'b0)) dut0 (
        .clk(clk), .rst_b(rst_b), .in_vld(in_vld), .d(d), .r(r),
        .lfsr_adv(adv0), .u(u0), .out_vld(ov0)
    );

    // Runs at a negedge: compares outputs of the previous posedge against the oldest entry.
    task automatic check_out();
        exp_t e;
        logic eadv;
        bit   ok;
        if (q.size() != 4) return;
`ifdef EF_SMSDAC_DITH_EN
        eadv = q[1].vld | q[2].vld | q[3].vld;
`else
        eadv = 1'b0;
`endif
        total++;
        if (adv1 !== eadv || adv0 !== eadv) begin
            bad++;
            $display("FAIL lfsr_adv: got %b/%b want %b", adv1, adv0, eadv);
        end
        e = q.pop_front();
        total++;
        if (ov1 !== e.vld || ov0 !== e.vld) begin
            bad++;
            $display("FAIL out_vld: got %b/%b want %b", ov1, ov0, e.vld);
        end
        if (e.vld) begin
            total++;
            if (e.exact) begin
                if (u1 !== e.eu || u0 !== e.eu) begin
                    bad++;
                    $display("FAIL u_exact: got %h/%h want %h", u1, u0, e.eu);
                end
            end else if ((^u1) === 1'bx || (^u0) === 1'bx ||
                         $countones(u1) != e.cnt || $countones(u0) != e.cnt) begin
                bad++;
                $display("FAIL popcount: got %h/%h want count %0d", u1, u0, e.cnt);
            end
            acc[0] += int'($countones(u1[3:0])) - int'($countones(u1[7:4]));
            acc[1] += int'($countones(u1[1:0])) - int'($countones(u1[3:2]));
            acc[2] += int'($countones(u1[5:4])) - int'($countones(u1[7:6]));
            for (int k = 0; k < 4; k++) acc[3+k] += int'(u1[2*k]) - int'(u1[2*k+1]);
            ok = 1'b1;
            for (int n = 0; n < 7; n++) if (acc[n] > 1 || acc[n] < -1) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL balance: acc %0d %0d %0d %0d %0d %0d %0d want within +-1",
                         acc[0], acc[1], acc[2], acc[3], acc[4], acc[5], acc[6]);
            end
            hold1 = u1;
        end else begin
            total++;
            if (u1 !== hold1 || u0 !== 8'h00) begin
                bad++;
                $display("FAIL bubble_u: got %h/%h want %h/00", u1, u0, hold1);
            end
        end
    endtask

    task automatic step(input bit v, input logic [3:0] dv, input bit ex, input logic [7:0] eu);
        exp_t e;
        @(negedge clk);
        check_out();
        in_vld  = v;
        d       = dv;
        e.vld   = v;
        e.exact = ex;
        e.eu    = eu;
        e.cnt   = (dv > 4'd8) ? 8 : int'(dv);
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 4'hF, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_b  = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        total++;
        if (u1 !== 8'h00 || u0 !== 8'h00 || ov1 !== 1'b0 || ov0 !== 1'b0 ||
            adv1 !== 1'b0 || adv0 !== 1'b0) begin
            bad++;
            $display("FAIL reset: u=%h/%h vld=%b/%b adv=%b/%b want all 0",
                     u1, u0, ov1, ov0, adv1, adv0);
        end
        rst_b = 1'b1;
        q.delete();
        e.vld = 1'b0; e.exact = 1'b0; e.eu = 8'h00; e.cnt = 0;
        for (int i = 0; i < 4; i++) q.push_back(e);
        hold1 = 8'h00;
        for (int n = 0; n < 7; n++) acc[n] = 0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 6; i++) step(1'b1, 4'd4, 1'b1, (i % 2 == 1) ? 8'hAA : 8'h55);
        drain();
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 4'd1, 1'b1, 8'h01);
        step(1'b1, 4'd1, 1'b1, 8'h10);
        step(1'b1, 4'd1, 1'b1, 8'h04);
        step(1'b1, 4'd1, 1'b1, 8'h40);
        drain();
    endtask

    task automatic test_clamp();
        do_reset();
        step(1'b1, 4'd8,  1'b1, 8'hFF);
        step(1'b1, 4'd12, 1'b1, 8'hFF);
        step(1'b0, 4'd1,  1'b0, 8'h00);
        step(1'b1, 4'd15, 1'b1, 8'hFF);
        step(1'b1, 4'd0,  1'b1, 8'h00);
        step(1'b0, 4'd3,  1'b0, 8'h00);
        step(1'b1, 4'd4,  1'b1, 8'h55);
        drain();
    endtask

    task automatic test_dither_dir();
        do_reset();
        r_fix = 7'h00;
`ifdef EF_SMSDAC_DITH_EN
        step(1'b1, 4'd4, 1'b1, 8'hAA);
`else
        step(1'b1, 4'd4, 1'b1, 8'h55);
`endif
        drain();
        do_reset();
        r_fix = 7'h7F;
        step(1'b1, 4'd4, 1'b1, 8'h55);
        drain();
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b1, 4'd4, 1'b1, 8'h55);
        step(1'b1, 4'd4, 1'b1, 8'hAA);
        step(1'b1, 4'd4, 1'b1, 8'h55);
        do_reset();
        step(1'b1, 4'd1, 1'b1, 8'h01);
        drain();
    endtask

    task automatic test_random();
        do_reset();
        use_lfsr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 1'b0, 8'h00);
        end
        drain();
        use_lfsr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_clamp();
        test_dither_dir();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
